dbus_arb: RTL and testbench

//  Shares one Wishbone-classic slave (normally the dbus sp_ram) between N masters:

---
 rtl/dbus_arb.sv | 178 +++++++++++++++++
 tb/tb_dbus_arb.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_arb.sv
// Wishbone-classic arbiter: port 0 has priority, a starvation counter forces
// round-robin turns for ports 1..N-1, and a watchdog completes hung slave cycles.
module dbus_arb #(
    parameter int          N            = 3,
    parameter int          STARVE_LIMIT = 4,
    parameter int          TIMEOUT      = 255,
    parameter logic [31:0] ERR_DATA     = 32'hDEAD_BEEF
) (
    input  logic            wb_clk,
    input  logic            wb_rst_n,
    input  logic [N-1:0]    m_cyc,
    input  logic [N-1:0]    m_we,
    input  logic [4*N-1:0]  m_sel,
    input  logic [32*N-1:0] m_adr,
    input  logic [32*N-1:0] m_dat,
    output logic [N-1:0]    m_ack,
    output logic [32*N-1:0] m_rdt,
    output logic            x_cyc,
    output logic            x_we,
    output logic [3:0]      x_sel,
    output logic [31:0]     x_adr,
    output logic [31:0]     x_dat,
    input  logic            x_ack,
    input  logic [31:0]     x_rdt,
    output logic [N-1:0]    grant,
    output logic            timeout
);

    localparam int PW      = $clog2(N);
    localparam int SW      = $clog2(STARVE_LIMIT + 1);
    localparam int WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit WD_EN   = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [N-1:0]    grant_r, m_ack_r;
    logic [32*N-1:0] m_rdt_r, rdt_next_s;
    logic            x_cyc_r, timeout_r;
    logic [SW-1:0]   starve_r;
    logic [PW-1:0]   ptr_r, low_win_s, win_s;
    logic [WDW-1:0]  wdog_r;
    logic            low_req_s, low_found_s, pick0_s, wd_expire_s;
    logic            arb_load_s, complete_s, fire_s;
    logic [31:0]     cap_s;

    // Arbitration: port 0 unless starved low ports are waiting, else rotate from ptr_r
    always_comb begin
        int idx;
        idx         = 0;
        low_win_s   = '0;
        low_found_s = 1'b0;
        low_req_s   = |m_cyc[N-1:1];
        for (int k = 0; k < N - 1; k++) begin
            idx = int'(ptr_r) + k;
            idx = (idx > N - 1) ? idx - (N - 1) : idx;
            if (!low_found_s && m_cyc[PW'(idx)]) begin
                low_found_s = 1'b1;
                low_win_s   = PW'(idx);
            end else begin
                low_found_s = low_found_s;
            end
        end
        pick0_s = m_cyc[0] && (!low_req_s || (starve_r < SW'(STARVE_LIMIT)));
        win_s   = pick0_s ? '0 : low_win_s;
    end

    assign wd_expire_s = WD_EN && (wdog_r == WDW'(TO_LAST));

    // Next state and completion decision
    always_comb begin
        state_s    = state_r;
        arb_load_s = 1'b0;
        complete_s = 1'b0;
        fire_s     = 1'b0;
        cap_s      = 32'd0;
        case (state_r)
            ST_IDLE: begin
                if (|m_cyc) begin
                    state_s    = ST_GRANT;
                    arb_load_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (x_ack) begin
                    state_s    = ST_DONE;
                    complete_s = 1'b1;
                    cap_s      = x_rdt;
                end else if (wd_expire_s) begin
                    state_s    = ST_DONE;
                    complete_s = 1'b1;
                    fire_s     = 1'b1;
                    cap_s      = x_we ? 32'd0 : ERR_DATA;
                end else begin
                    state_s = ST_GRANT;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Slave-side mux and read-data slot placement, both steered by the one-hot grant
    always_comb begin
        x_we       = 1'b0;
        x_sel      = 4'd0;
        x_adr      = 32'd0;
        x_dat      = 32'd0;
        rdt_next_s = '0;
        for (int i = 0; i < N; i++) begin
            x_we  = x_we | (m_we[i] & grant_r[i]);
            x_sel = x_sel | (m_sel[4*i +: 4] & {4{grant_r[i]}});
            x_adr = x_adr | (m_adr[32*i +: 32] & {32{grant_r[i]}});
            x_dat = x_dat | (m_dat[32*i +: 32] & {32{grant_r[i]}});
            rdt_next_s[32*i +: 32] = grant_r[i] ? cap_s : 32'd0;
        end
    end

    // State, grant, watchdog and fairness registers
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            state_r   <= ST_IDLE;
            grant_r   <= '0;
            x_cyc_r   <= 1'b0;
            m_ack_r   <= '0;
            m_rdt_r   <= '0;
            timeout_r <= 1'b0;
            starve_r  <= '0;
            ptr_r     <= PW'(1);
            wdog_r    <= '0;
        end else begin
            state_r   <= state_s;
            x_cyc_r   <= (state_s == ST_GRANT);
            m_ack_r   <= complete_s ? grant_r : '0;
            m_rdt_r   <= complete_s ? rdt_next_s : '0;
            timeout_r <= fire_s;
            wdog_r    <= ((state_r == ST_GRANT) && !complete_s) ? wdog_r + WDW'(1) : '0;
            if (arb_load_s) begin
                grant_r <= {{(N-1){1'b0}}, 1'b1} << win_s;
            end else if (state_r == ST_DONE) begin
                grant_r <= '0;
            end else begin
                grant_r <= grant_r;
            end
            // Starvation counts only port-0 wins that bypassed a waiting low port
            if (arb_load_s && pick0_s) begin
                if (!low_req_s) begin
                    starve_r <= '0;
                end else if (starve_r == SW'(STARVE_LIMIT)) begin
                    starve_r <= starve_r;
                end else begin
                    starve_r <= starve_r + SW'(1);
                end
                ptr_r <= ptr_r;
            end else if (arb_load_s) begin
                starve_r <= '0;
                ptr_r    <= (low_win_s == PW'(N - 1)) ? PW'(1) : low_win_s + PW'(1);
            end else begin
                starve_r <= starve_r;
                ptr_r    <= ptr_r;
            end
        end
    end

    assign m_ack   = m_ack_r;
    assign m_rdt   = m_rdt_r;
    assign x_cyc   = x_cyc_r;
    assign grant   = grant_r;
    assign timeout = timeout_r;

endmodule

// File: tb/tb_dbus_arb.sv
// Directed and randomized bench for dbus_arb (N=3, STARVE_LIMIT=4, TIMEOUT=255)
// with a transaction-level arbitration model.
module tb_dbus_arb;

    localparam int N = 3;
    localparam int LIMIT = 4;

    logic          wb_clk = 1'b0;
    logic          wb_rst_n = 1'b0;
    logic [2:0]    m_cyc = '0, m_we = '0;
    logic [11:0]   m_sel = '0;
    logic [95:0]   m_adr = '0, m_dat = '0;
    logic [2:0]    m_ack;
    logic [95:0]   m_rdt;
    logic          x_cyc, x_we;
    logic [3:0]    x_sel;
    logic [31:0]   x_adr, x_dat;
    logic          x_ack = 1'b0;
    logic [31:0]   x_rdt = '0;
    logic [2:0]    grant;
    logic          timeout;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] adr_a [3];
    logic [31:0] dat_a [3];
    logic        we_a  [3];
    logic [3:0]  sel_a [3];
    int m_starve, m_ptr;

    dbus_arb dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .m_cyc(m_cyc), .m_we(m_we),
        .m_sel(m_sel), .m_adr(m_adr), .m_dat(m_dat), .m_ack(m_ack), .m_rdt(m_rdt),
        .x_cyc(x_cyc), .x_we(x_we), .x_sel(x_sel), .x_adr(x_adr), .x_dat(x_dat),
        .x_ack(x_ack), .x_rdt(x_rdt), .grant(grant), .timeout(timeout)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic step();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            m_adr[32*i +: 32] = adr_a[i];
            m_dat[32*i +: 32] = dat_a[i];
            m_we[i]           = we_a[i];
            m_sel[4*i +: 4]   = sel_a[i];
        end
    endtask

    task automatic raise(input int i);
        adr_a[i] = $urandom;
        dat_a[i] = $urandom;
        we_a[i]  = 1'($urandom_range(0, 1));
        sel_a[i] = 4'($urandom_range(0, 15));
        m_cyc[i] = 1'b1;
        pack();
    endtask

    task automatic do_reset();
        wb_rst_n = 1'b0;
        m_cyc    = '0;
        x_ack    = 1'b0;
        step();
        step();
        wb_rst_n = 1'b1;
        m_starve = 0;
        m_ptr    = 1;
    endtask

    // Reference arbitration rules applied to the request set seen in an idle cycle
    task automatic model_pick(input logic [2:0] req, output int w);
        bit low;
        bit found;
        int j;
        low   = (req[2:1] != 2'b00);
        found = 0;
        w     = -1;
        if (req[0] && (!low || m_starve < LIMIT)) begin
            w        = 0;
            m_starve = low ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
        end else begin
            for (int k = 0; k < N - 1; k++) begin
                j = 1 + ((m_ptr - 1 + k) % (N - 1));
                if (!found && req[j]) begin
                    found = 1;
                    w     = j;
                end
            end
            m_starve = 0;
            m_ptr    = (w == N - 1) ? 1 : w + 1;
        end
    endtask

    task automatic check_grant(input int w);
        chk("grant", grant, 128'(3'b001 << w));
        chk("x_cyc_rise", x_cyc, 1);
        chk("x_adr", x_adr, adr_a[w]);
        chk("x_dat", x_dat, dat_a[w]);
        chk("x_we_sel", {x_we, x_sel}, {we_a[w], sel_a[w]});
        chk("no_early_ack", m_ack, 0);
    endtask

    // From the first GRANT cycle: slave acks after lat wait cycles, then DONE and IDLE
    task automatic serve(input int w, input int lat, input logic [31:0] rd);
        logic [95:0] exp;
        exp = '0;
        exp[32*w +: 32] = rd;
        for (int c = 0; c < lat; c++) begin
            step();
            chk("hold", {x_cyc, m_ack, timeout}, {1'b1, 3'b000, 1'b0});
        end
        x_ack = 1'b1;
        x_rdt = rd;
        step();
        x_ack = 1'b0;
        x_rdt = $urandom;
        chk("m_ack", m_ack, 128'(3'b001 << w));
        chk("m_rdt", m_rdt, exp);
        chk("done_bus", {x_cyc, timeout, grant}, {2'b00, 3'b001 << w});
        m_cyc[w] = 1'b0;
        step();
        chk("idle", {grant, x_cyc, m_ack, timeout}, 128'd0);
        chk("idle_rdt", m_rdt, 0);
        chk("idle_adr", x_adr, 0);
    endtask

    task automatic timeout_case(input int w, input logic we);
        int cnt;
        logic [95:0] exp;
        raise(w);
        we_a[w] = we;
        pack();
        step();
        check_grant(w);
        cnt = 0;
        while (x_cyc && cnt < 300) begin
            cnt++;
            step();
        end
        exp = '0;
        exp[32*w +: 32] = we ? 32'd0 : 32'hDEAD_BEEF;
        chk("wd_cycles", cnt, 255);
        chk("wd_pulse", {timeout, m_ack}, {1'b1, 3'b001 << w});
        chk("wd_rdt", m_rdt, exp);
        m_cyc[w] = 1'b0;
        step();
        chk("wd_after", {timeout, grant, m_ack}, 128'd0);
    endtask

    initial begin
        int order3 [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0};
        int order4 [5]  = '{1, 2, 1, 2, 0};
        int w;

        // Reset held with every master requesting
        wb_rst_n = 1'b0;
        for (int i = 0; i < N; i++) raise(i);
        step();
        step();
        chk("rst_outs", {grant, x_cyc, m_ack, timeout}, 128'd0);
        chk("rst_rdt", m_rdt, 0);
        chk("rst_bus", {x_we, x_sel, x_adr, x_dat}, 128'd0);
        wb_rst_n = 1'b1;
        step();
        check_grant(0);
        serve(0, 0, $urandom);

        // Single read from port 1
        do_reset();
        raise(1);
        adr_a[1] = 32'h0000_0100;
        we_a[1]  = 1'b0;
        pack();
        step();
        check_grant(1);
        serve(1, 2, 32'h1234_5678);

        // All three requesting continuously
        do_reset();
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < N; i++) if (!m_cyc[i]) raise(i);
            step();
            check_grant(order3[k]);
            serve(order3[k], $urandom_range(0, 2), $urandom);
        end

        // Low ports alternate; port 0 joins at the end
        do_reset();
        for (int k = 0; k < 5; k++) begin
            for (int i = 1; i < N; i++) if (!m_cyc[i]) raise(i);
            if (k == 4) raise(0);
            step();
            check_grant(order4[k]);
            serve(order4[k], 1, $urandom);
        end

        // Watchdog on a read and on a write, then normal traffic and the ack-vs-expiry tie
        do_reset();
        timeout_case(0, 1'b0);
        raise(1);
        step();
        check_grant(1);
        serve(1, 1, $urandom);
        timeout_case(2, 1'b1);
        raise(0);
        step();
        check_grant(0);
        serve(0, 254, 32'hCAFE_F00D);

        // Reset in the middle of a granted cycle
        do_reset();
        raise(2);
        step();
        check_grant(2);
        step();
        wb_rst_n = 1'b0;
        step();
        chk("midrst", {x_cyc, grant, m_ack, timeout}, 128'd0);
        wb_rst_n = 1'b1;
        m_starve = 0;
        m_ptr    = 1;
        step();
        check_grant(2);
        serve(2, 0, $urandom);

        // Randomized traffic against the reference model, with stray idle acks
        do_reset();
        for (int t = 0; t < 150; t++) begin
            for (int i = 0; i < N; i++) if (!m_cyc[i] && $urandom_range(0, 1) == 1) raise(i);
            if (m_cyc == 3'b000) raise($urandom_range(0, N - 1));
            if ($urandom_range(0, 3) == 0) x_ack = 1'b1;
            model_pick(m_cyc, w);
            step();
            x_ack = 1'b0;
            check_grant(w);
            serve(w, $urandom_range(0, 3), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
